// File: rtl/filter_sequencer_pkg.sv
// ============================================================================
// Module      : filter_sequencer_pkg
// Description : Shared definitions for the filter sequencer: FSM state
//               encodings, error codes and the configuration validity check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_sequencer_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CHECK  = 3'd1;
    localparam logic [2:0] c_ST_LAUNCH = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_RUN    = 3'd4;
    localparam logic [2:0] c_ST_NEXT   = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;
    localparam logic [2:0] c_ST_ERROR  = 3'd7;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_CFG     = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] c_ERR_ABORT   = 2'd3;

    // A frame is runnable only with a non-zero, word-aligned size, a
    // non-zero width and at least one pass.
    function automatic logic cfg_is_valid(
        input logic [31:0] size,
        input logic [9:0]  width,
        input logic        passes_nonzero
    );
        return (size != 32'd0) && (width != 10'd0) &&
               (size[1:0] == 2'b00) && passes_nonzero;
    endfunction

endpackage

`default_nettype wire

// File: rtl/filter_seq_watchdog.sv
// ============================================================================
// Module      : filter_seq_watchdog
// Description : Per-pass watchdog. Counts enabled cycles since the last clear
//               and flags expiry on the enabled cycle that brings the count
//               up to the limit.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clear       - restart the count at zero
//               i_enable      - count this cycle
//               i_limit       - number of enabled cycles allowed
//               o_expired     - this enabled cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_seq_watchdog #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + WIDTH'(1);

    // Compare against the incremented value so expiry lands on exactly the
    // i_limit-th enabled cycle rather than one cycle later.
    assign o_expired = i_enable && (w_count_inc == i_limit);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_count_inc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/filter_sequencer.sv
// ============================================================================
// Module      : filter_sequencer
// Description : Frame-level controller for the filter datapath. Latches host
//               configuration on start, validates it, pulses the filter's
//               refresh once per pass, waits for is_end and repeats for the
//               requested number of passes. Provides abort, a per-pass
//               watchdog, busy/done/error status and a RUN cycle counter.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               start, abort            - host controls
//               cfg_size/width/passes   - host configuration
//               filt_is_end             - end-of-frame from the filter
//               filt_refresh/size/width - filter control outputs
//               busy, done, error,
//               err_code, pass_idx,
//               cycle_count             - status back to the host
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_sequencer
    import filter_sequencer_pkg::*;
#(
    parameter int PASS_WIDTH     = 4,
    parameter int TIMEOUT_MARGIN = 64,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           cfg_size,
    input  logic [9:0]            cfg_width,
    input  logic [PASS_WIDTH-1:0] cfg_passes,
    input  logic                  filt_is_end,
    output logic                  filt_refresh,
    output logic [31:0]           filt_size,
    output logic [9:0]            filt_width,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic [31:0]           cycle_count
);

    // One bit of headroom beyond the shifted 32-bit size so adding the
    // margin can never wrap, whatever size the host supplies.
    localparam int c_WD_W     = 35;
    localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_next_state;

    logic [31:0]           r_size;
    logic [9:0]            r_width;
    logic [PASS_WIDTH-1:0] r_passes;
    logic [PASS_WIDTH-1:0] r_pass_idx;
    logic [31:0]           r_cycle_count;
    logic                  r_error;
    logic [1:0]            r_err_code;
    logic [c_SETTLE_W-1:0] r_settle_cnt;

    logic                  w_start_accept;
    logic                  w_cfg_ok;
    logic                  w_last_pass;
    logic                  w_settle_last;
    logic                  w_err_set;
    logic [1:0]            w_err_kind;
    logic                  w_refresh;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_pass_clear;
    logic                  w_settle_en;
    logic                  w_run;
    logic                  w_wd_expired;
    logic [c_WD_W-1:0]     w_wd_limit;

    assign w_start_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_ERROR));
    assign w_cfg_ok       = cfg_is_valid(r_size, r_width, r_passes != '0);
    assign w_last_pass    = (r_pass_idx == (r_passes - PASS_WIDTH'(1)));
    assign w_settle_last  = (r_settle_cnt == c_SETTLE_W'(SETTLE_CYCLES - 1));
    assign w_wd_limit     = ({3'b000, r_size} << 2) + c_WD_W'(TIMEOUT_MARGIN);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic, including which error (if any) is being entered
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        w_err_kind   = c_ERR_NONE;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next_state = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (w_cfg_ok) begin
                    w_next_state = c_ST_LAUNCH;
                end else begin
                    w_next_state = c_ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_kind   = c_ERR_CFG;
                end
            end
            c_ST_LAUNCH: begin
                w_next_state = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                // is_end may still reflect the previous pass here, so only
                // abort and the settle count matter.
                if (abort) begin
                    w_next_state = c_ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_kind   = c_ERR_ABORT;
                end else if (w_settle_last) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_next_state = c_ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_kind   = c_ERR_ABORT;
                end else if (filt_is_end) begin
                    w_next_state = c_ST_NEXT;
                end else if (w_wd_expired) begin
                    w_next_state = c_ST_ERROR;
                    w_err_set    = 1'b1;
                    w_err_kind   = c_ERR_TIMEOUT;
                end
            end
            c_ST_NEXT: begin
                w_next_state = w_last_pass ? c_ST_DONE : c_ST_LAUNCH;
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_ERROR: begin
                if (start) w_next_state = c_ST_CHECK;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore): all pulses are a function of the state only
    // ------------------------------------------------------------------------
    always_comb begin
        w_refresh    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_pass_clear = 1'b0;
        w_settle_en  = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            c_ST_CHECK: begin
                w_busy = 1'b1;
            end
            c_ST_LAUNCH: begin
                w_busy       = 1'b1;
                w_refresh    = 1'b1;
                w_pass_clear = 1'b1;
            end
            c_ST_SETTLE: begin
                w_busy      = 1'b1;
                w_settle_en = 1'b1;
            end
            c_ST_RUN: begin
                w_busy = 1'b1;
                w_run  = 1'b1;
            end
            c_ST_NEXT: begin
                w_busy = 1'b1;
            end
            c_ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Configuration latch, pass counter, cycle counter and error status
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_size        <= '0;
            r_width       <= '0;
            r_passes      <= '0;
            r_pass_idx    <= '0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
            r_err_code    <= c_ERR_NONE;
        end else if (w_start_accept) begin
            r_size        <= cfg_size;
            r_width       <= cfg_width;
            r_passes      <= cfg_passes;
            r_pass_idx    <= '0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
            r_err_code    <= c_ERR_NONE;
        end else begin
            if (w_err_set) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_kind;
            end
            if (w_run && (r_cycle_count != 32'hFFFF_FFFF)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if ((r_state == c_ST_NEXT) && !w_last_pass) begin
                r_pass_idx <= r_pass_idx + PASS_WIDTH'(1);
            end
        end
    end

    // Settle counter restarts with every pass
    always_ff @(posedge clock) begin
        if (reset || w_pass_clear) begin
            r_settle_cnt <= '0;
        end else if (w_settle_en && !w_settle_last) begin
            r_settle_cnt <= r_settle_cnt + c_SETTLE_W'(1);
        end
    end

    filter_seq_watchdog #(
        .WIDTH (c_WD_W)
    ) u_watchdog (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (w_pass_clear),
        .i_enable  (w_run),
        .i_limit   (w_wd_limit),
        .o_expired (w_wd_expired)
    );

    assign filt_refresh = w_refresh;
    assign filt_size    = r_size;
    assign filt_width   = r_width;
    assign busy         = w_busy;
    assign done         = w_done;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign pass_idx     = r_pass_idx;
    assign cycle_count  = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_filter_sequencer.sv
// ============================================================================
// Module      : tb_filter_sequencer
// Description : Self-checking bench for filter_sequencer. Stimulus pushes the
//               expected refresh/done/error events into a queue; a monitor
//               pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_sequencer;

    localparam int PW     = 4;
    localparam int MARGIN = 64;
    localparam int SETTLE = 2;

    localparam int K_REFRESH = 0;
    localparam int K_DONE    = 1;
    localparam int K_ERROR   = 2;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic [31:0]   cfg_size;
    logic [9:0]    cfg_width;
    logic [PW-1:0] cfg_passes;
    logic          filt_is_end;
    logic          filt_refresh;
    logic [31:0]   filt_size;
    logic [9:0]    filt_width;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [PW-1:0] pass_idx;
    logic [31:0]   cycle_count;

    typedef struct {
        int          kind;
        int          pidx;
        int          code;
        logic [31:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_error = 1'b0;

    filter_sequencer #(
        .PASS_WIDTH     (PW),
        .TIMEOUT_MARGIN (MARGIN),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_size     (cfg_size),
        .cfg_width    (cfg_width),
        .cfg_passes   (cfg_passes),
        .filt_is_end  (filt_is_end),
        .filt_refresh (filt_refresh),
        .filt_size    (filt_size),
        .filt_width   (filt_width),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .pass_idx     (pass_idx),
        .cycle_count  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int pidx, input int code, input logic [31:0] cyc);
        exp_t e;
        e.kind   = kind;
        e.pidx   = pidx;
        e.code   = code;
        e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d, expected no event (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("sb_event_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    K_REFRESH: chk("sb_refresh_pass_idx", pass_idx, e.pidx);
                    K_DONE: begin
                        chk("sb_done_pass_idx", pass_idx, e.pidx);
                        chk("sb_done_cycle_count", cycle_count, e.cycles);
                    end
                    default: begin
                        chk("sb_error_code", err_code, e.code);
                        chk("sb_error_cycle_count", cycle_count, e.cycles);
                    end
                endcase
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            if (filt_refresh === 1'b1) sb_check(K_REFRESH);
            if (done === 1'b1) sb_check(K_DONE);
            if ((error === 1'b1) && !prev_error) sb_check(K_ERROR);
        end
        prev_error = (error === 1'b1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_cfg(input logic [31:0] sz, input logic [9:0] wd, input logic [PW-1:0] ps);
        cfg_size   = sz;
        cfg_width  = wd;
        cfg_passes = ps;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_refresh();
        int n = 0;
        while ((filt_refresh !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        chk("refresh_seen", filt_refresh, 1);
    endtask

    // Called in the LAUNCH cycle; presents is_end on the k-th RUN cycle
    task automatic run_pass(input int k);
        repeat (SETTLE + k) tick();
        filt_is_end = 1'b1;
        tick();
        filt_is_end = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_refresh"}, filt_refresh, 0);
        chk({tag, "_size"}, filt_size, 0);
        chk({tag, "_width"}, filt_width, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_pass_idx"}, pass_idx, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_size    = '0;
        cfg_width   = '0;
        cfg_passes  = '0;
        filt_is_end = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Single pass, is_end on the 300th RUN cycle
        push(K_REFRESH, 0, 0, 0);
        push(K_DONE, 0, 0, 300);
        start_cfg(32'd1024, 10'd32, 4'd1);
        chk("check_cycle_no_refresh", filt_refresh, 0);
        chk("check_cycle_busy", busy, 1);
        tick();
        chk("start_to_refresh_2cyc", filt_refresh, 1);
        chk("latched_size", filt_size, 1024);
        chk("latched_width", filt_width, 32);
        run_pass(300);
        repeat (3) tick();
        chk("single_pass_idle", busy, 0);
        chk("single_pass_count_held", cycle_count, 300);

        // Three passes of 10, 20 and 30 RUN cycles
        push(K_REFRESH, 0, 0, 0);
        push(K_REFRESH, 1, 0, 0);
        push(K_REFRESH, 2, 0, 0);
        push(K_DONE, 2, 0, 60);
        start_cfg(32'd64, 10'd8, 4'd3);
        wait_refresh();
        run_pass(10);
        wait_refresh();
        run_pass(20);
        wait_refresh();
        run_pass(30);
        repeat (3) tick();

        // Bad configurations, then recovery with a valid one
        push(K_ERROR, 0, 1, 0);
        start_cfg(32'd1026, 10'd32, 4'd1);
        repeat (3) tick();
        chk("badcfg_error", error, 1);
        chk("badcfg_code", err_code, 1);
        chk("badcfg_not_busy", busy, 0);
        push(K_ERROR, 0, 1, 0);
        start_cfg(32'd64, 10'd8, 4'd0);
        repeat (3) tick();
        push(K_REFRESH, 0, 0, 0);
        push(K_DONE, 0, 0, 3);
        start_cfg(32'd16, 10'd4, 4'd1);
        chk("restart_clears_error", error, 0);
        chk("restart_clears_code", err_code, 0);
        wait_refresh();
        run_pass(3);
        repeat (3) tick();

        // is_end stale through SETTLE, then absent: timeout after 4096+64
        push(K_REFRESH, 0, 0, 0);
        push(K_ERROR, 0, 2, 32'd4160);
        filt_is_end = 1'b1;
        start_cfg(32'd1024, 10'd32, 4'd1);
        wait_refresh();
        repeat (SETTLE + 1) tick();
        filt_is_end = 1'b0;
        begin
            int n = 0;
            while ((error !== 1'b1) && (n < 5000)) begin
                tick();
                n++;
            end
        end
        chk("timeout_error", error, 1);
        chk("timeout_code", err_code, 2);

        // abort and is_end together on RUN cycle 5; start while busy ignored
        push(K_REFRESH, 0, 0, 0);
        push(K_ERROR, 0, 3, 5);
        start_cfg(32'd256, 10'd16, 4'd2);
        wait_refresh();
        repeat (SETTLE + 1) tick();
        start_cfg(32'd8, 10'd2, 4'd1);
        chk("busy_start_size_kept", filt_size, 256);
        chk("busy_start_width_kept", filt_width, 16);
        repeat (3) tick();
        abort       = 1'b1;
        filt_is_end = 1'b1;
        tick();
        abort       = 1'b0;
        filt_is_end = 1'b0;
        tick();
        chk("abort_code", err_code, 3);

        // Reset in the middle of RUN
        push(K_REFRESH, 0, 0, 0);
        start_cfg(32'd64, 10'd8, 4'd1);
        wait_refresh();
        repeat (SETTLE + 5) tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("midrun_reset");
        reset = 1'b0;
        repeat (5) tick();
        chk("no_refresh_after_reset", filt_refresh, 0);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
